// File: rtl/reg_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds default widths and depth, the register count, and the writeback request
// record that holds a destination address and its data.
package reg_wb_arbiter_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 5;
  localparam int FIFO_DEPTH_DEF = 2;
  localparam int NUM_REGS_DEF   = 2 ** ADDR_W_DEF;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO that holds queued register writes.
// Ports: clk/rst (async active-high); push/push_addr/push_data enqueue; pop dequeues;
//        head_* shows the oldest entry; count/empty report occupancy; ent_vld/ent_addr expose every slot.
module wb_fifo
  import reg_wb_arbiter_pkg::*;
#(
  parameter int AW    = ADDR_W_DEF,
  parameter int DW    = DATA_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                     empty,
  output logic [DEPTH-1:0]         ent_vld,
  output logic [DEPTH-1:0][AW-1:0] ent_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // A slot is live when its distance from the read pointer (mod DEPTH) is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PW-1:0] off;
    assign off         = PW'(g) - rd_ptr;
    assign ent_vld[g]  = (CW'(off) < count);
    assign ent_addr[g] = mem_addr[g];
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the single register-file write port between requester A (pipeline) and B (multi-cycle unit).
// Ports: a_*/b_* valid-ready write requests; wr_en/wr_addr/wr_data registered write port;
//        grant_b marks a B-sourced write; pending flags registers with queued or issuing writes.
// Build option RR_ARB_EN: round-robin between A and B when both are waiting (default: A always wins).
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [2**ADDR_W-1:0]  pending,
  output logic                  grant_b
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                             a_empty, b_empty;
  logic [CW-1:0]                    a_count, b_count;
  logic [ADDR_W-1:0]                a_head_addr, b_head_addr;
  logic [DATA_W-1:0]                a_head_data, b_head_data;
  logic [FIFO_DEPTH-1:0]            a_ent_vld, b_ent_vld;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] a_ent_addr, b_ent_addr;
  logic                             a_push, b_push;
  logic                             a_pop, b_pop;
  logic                             sel_b;
  logic                             any_req;

  // Ready comes from registered occupancy only, so a full FIFO refuses even while it pops.
  assign a_ready = (a_count < CW'(FIFO_DEPTH));
  assign b_ready = (b_count < CW'(FIFO_DEPTH));

  // Writes to register 0 are accepted but dropped on the floor.
  assign a_push = a_valid && a_ready && (a_addr != '0);
  assign b_push = b_valid && b_ready && (b_addr != '0);

  assign any_req = !a_empty || !b_empty;

`ifdef RR_ARB_EN
  logic contested;
  logic rr_b;   // 1: next contested grant goes to B

  assign contested = !a_empty && !b_empty;
  assign sel_b     = contested ? rr_b : !b_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rr_b <= 1'b0;
    else if (contested) rr_b <= ~rr_b;
  end
`else
  assign sel_b = a_empty && !b_empty;
`endif

  assign a_pop = !a_empty && !sel_b;
  assign b_pop = !b_empty && sel_b;

  wb_fifo #(.AW(ADDR_W), .DW(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (a_push),
    .push_addr (a_addr),
    .push_data (a_data),
    .pop       (a_pop),
    .head_addr (a_head_addr),
    .head_data (a_head_data),
    .count     (a_count),
    .empty     (a_empty),
    .ent_vld   (a_ent_vld),
    .ent_addr  (a_ent_addr)
  );

  wb_fifo #(.AW(ADDR_W), .DW(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (b_push),
    .push_addr (b_addr),
    .push_data (b_data),
    .pop       (b_pop),
    .head_addr (b_head_addr),
    .head_data (b_head_data),
    .count     (b_count),
    .empty     (b_empty),
    .ent_vld   (b_ent_vld),
    .ent_addr  (b_ent_addr)
  );

  // Address and data hold across idle cycles; only wr_en drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      grant_b <= 1'b0;
    end else begin
      wr_en <= any_req;
      if (any_req) begin
        wr_addr <= sel_b ? b_head_addr : a_head_addr;
        wr_data <= sel_b ? b_head_data : a_head_data;
        grant_b <= sel_b;
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (a_ent_vld[i]) pending[a_ent_addr[i]] = 1'b1;
      if (b_ent_vld[i]) pending[b_ent_addr[i]] = 1'b1;
    end
    if (wr_en) pending[wr_addr] = 1'b1;
    pending[0] = 1'b0;
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters.
- Requester A is the main pipeline writeback. Requester B is the multi-cycle unit (mul/div or load return).
- Each requester is buffered in its own small FIFO. The block issues at most one registered write per cycle and exports a per-register pending-write vector that the hazard unit uses to stall reads of registers with queued writes.

Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
- FIFO_DEPTH, 2, entries per requester FIFO; power of two, >= 2

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  requester A has a write
- a_ready  out  1  A FIFO can accept
- a_addr  in  ADDR_W  A destination register
- a_data  in  DATA_W  A write data
- b_valid  in  1  requester B has a write
- b_ready  out  1  B FIFO can accept
- b_addr  in  ADDR_W  B destination register
- b_data  in  DATA_W  B write data
- wr_en  out  1  register-file write enable (registered)
- wr_addr  out  ADDR_W  register-file write address (registered)
- wr_data  out  DATA_W  register-file write data (registered)
- pending  out  NUM_REGS  bit r set while any queued or issuing write targets r
- grant_b  out  1  registered; 1 when the current wr_* came from B

Behaviour:
- Reset (async, rst=1): both FIFOs empty; wr_en=0, wr_addr=0, wr_data=0, grant_b=0; pending=0; rr pointer favours A.
- Handshake:
  - x_ready = (count_x < FIFO_DEPTH); it depends only on registered state, never on x_valid.
  - A push occurs at a posedge with x_valid && x_ready.
  - x_valid with x_ready=0 is held by the requester. Payload is sampled only at the push edge.
- Address 0: an accepted write with addr==0 is discarded. It is not pushed, is not issued and sets no pending bit. Ready semantics are unchanged.
- Arbitration at each posedge, using FIFO heads as they stood before that edge:
  - Neither non-empty: wr_en<=0; wr_addr, wr_data and grant_b hold.
  - One non-empty: pop it; drive wr_*<=head, wr_en<=1, grant_b<=source.
  - Both non-empty: fixed priority, A wins. B waits.
- Latency: a write pushed at edge k is eligible at edge k+1 at the earliest, so wr_en is high in the cycle following edge k+1. There is no bypass from input to output.
- Throughput: one write per cycle. A pop and a push on the same FIFO at the same edge are both performed. Ready is based on the pre-edge count, so a full FIFO does not accept even while popping.
- Ordering: per requester strictly FIFO. Across requesters, grant order defines the final register value.
- pending: combinational OR over all valid FIFO entries plus the output stage (wr_en && wr_addr). Bit 0 is always 0.
- Reset mid-operation: all queued writes are lost and wr_en drops immediately (asynchronous).

Optional Feature:
- RR_ARB_EN defined: when both FIFOs are non-empty, round-robin replaces fixed priority. The rr pointer toggles to the other requester after each contested grant. An uncontested grant does not move the pointer.
- Undefined: fixed priority, A over B; B can starve under continuous A traffic.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, NUM_REGS, FIFO_DEPTH default, and a wb_req_t struct {addr, data}.
- One sub-module, wb_fifo: parameterised synchronous FIFO with push/pop/count/full/empty, async active-high reset, and an entry-valid/address view for pending. It is instantiated twice.

Test Plan:
- Single A write: push a_addr=5, a_data=0xDEADBEEF at edge 1 -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, grant_b=0 in cycle after edge 2; pending[5]=1 from edge 1 until wr_en deasserts.
- Contention: A (3, 0x11) and B (4, 0x22) pushed at the same edge -> A issued first, B next cycle. With RR_ARB_EN, a second contested pair issues B before A.
- Back-pressure: 3 consecutive B pushes with no pops possible (A saturating, fixed priority) -> b_ready=0 after 2 entries; third write accepted only after B count drops; no data lost or duplicated.
- Address zero: push a_addr=0, a_data=0x1234 -> a_ready unaffected, wr_en never asserted for it, pending=0.
- Async reset mid-stream: assert rst between edges with both FIFOs holding 2 entries -> wr_en, pending and grant_b drop immediately; a_ready=b_ready=1; after release, no stale writes issue.
